// File: rtl/bit_deserializer.sv
// Serial-to-parallel converter: accepts one bit per handshake into a WIDTH-bit word
// and presents each completed word on a registered valid/ready output.
module bit_deserializer #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     in_valid,
    input  logic                     in_bit,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_data,
    input  logic                     out_ready,
    output logic [$clog2(WIDTH)-1:0] bit_index
);

    localparam int IW = $clog2(WIDTH);
    localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

    logic [IW-1:0]    r_idx;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] r_data;
    logic             r_valid;

    logic             w_ready;
    logic             w_accept;
    logic             w_last;
    logic [IW-1:0]    w_pos;
    logic [WIDTH-1:0] w_word;

    // Only the completing bit has to wait for a stalled output slot.
    assign w_ready  = !clear && !((r_idx == LAST) && r_valid && !out_ready);
    assign w_accept = in_valid && w_ready;
    assign w_last   = w_accept && (r_idx == LAST);
    assign w_pos    = LSB_FIRST ? r_idx : (LAST - r_idx);

    // Partial word with the incoming bit merged at its destination position.
    always_comb begin
        w_word        = r_shift;
        w_word[w_pos] = in_bit;
    end

    // Bit-index counter, partial register and output word holding register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx   <= {IW{1'b0}};
            r_shift <= {WIDTH{1'b0}};
            r_data  <= {WIDTH{1'b0}};
            r_valid <= 1'b0;
        end else begin
            if (clear) begin
                r_idx   <= {IW{1'b0}};
                r_shift <= {WIDTH{1'b0}};
            end else if (w_accept) begin
                r_idx   <= r_idx + {{(IW-1){1'b0}}, 1'b1};
                r_shift <= w_word;
            end else begin
                r_idx   <= r_idx;
                r_shift <= r_shift;
            end

            // A completion on the same edge as a transfer keeps out_valid high.
            if (w_last) begin
                r_data  <= w_word;
                r_valid <= 1'b1;
            end else if (r_valid && out_ready) begin
                r_valid <= 1'b0;
            end else begin
                r_valid <= r_valid;
            end
        end
    end

    assign in_ready  = w_ready;
    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign bit_index = r_idx;

endmodule

// File: tb/tb_bit_deserializer.sv
// Bench for bit_deserializer: LSB-first and MSB-first instances share one stimulus
// stream and are compared every cycle against a word-level reference model.
module tb_bit_deserializer;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clear = 1'b0;
    logic in_valid = 1'b0;
    logic in_bit = 1'b0;
    logic out_ready = 1'b0;

    logic         in_ready1, out_valid1, in_ready0, out_valid0;
    logic [W-1:0] out_data1, out_data0;
    logic [2:0]   bit_index1, bit_index0;

    int n_chk = 0;
    int n_pass = 0;

    // reference model state
    int           m_cnt = 0;
    logic         m_bits [W];
    logic         m_valid = 1'b0;
    logic [W-1:0] m_lsb = '0;
    logic [W-1:0] m_msb = '0;
    int           m_words = 0;

    always #5 clk = ~clk;

    bit_deserializer #(.WIDTH(W), .LSB_FIRST(1'b1)) u_lsb (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_bit(in_bit),
        .in_ready(in_ready1), .out_valid(out_valid1), .out_data(out_data1),
        .out_ready(out_ready), .bit_index(bit_index1));

    bit_deserializer #(.WIDTH(W), .LSB_FIRST(1'b0)) u_msb (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_bit(in_bit),
        .in_ready(in_ready0), .out_valid(out_valid0), .out_data(out_data0),
        .out_ready(out_ready), .bit_index(bit_index0));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_cnt = 0; m_valid = 1'b0; m_lsb = '0; m_msb = '0;
    endtask

    // One clock cycle: drive, compare everything against the model, advance the model.
    task automatic step(input logic v, input logic b, input logic o, input logic c,
                        output logic rdy_seen);
        logic exp_rdy, acc, xfer, done;
        @(negedge clk);
        in_valid = v; in_bit = b; out_ready = o; clear = c;
        #1;
        exp_rdy = !c && !((m_cnt == W-1) && m_valid && !o);
        rdy_seen = in_ready1;
        chk("in_ready_lsb", 32'(in_ready1), 32'(exp_rdy));
        chk("in_ready_msb", 32'(in_ready0), 32'(exp_rdy));
        chk("out_valid_lsb", 32'(out_valid1), 32'(m_valid));
        chk("out_valid_msb", 32'(out_valid0), 32'(m_valid));
        chk("out_data_lsb", 32'(out_data1), 32'(m_lsb));
        chk("out_data_msb", 32'(out_data0), 32'(m_msb));
        chk("bit_index_lsb", 32'(bit_index1), 32'(m_cnt));
        chk("bit_index_msb", 32'(bit_index0), 32'(m_cnt));
        acc = v && exp_rdy;
        xfer = m_valid && o;
        done = 1'b0;
        if (c) begin
            m_cnt = 0;
        end else if (acc) begin
            m_bits[m_cnt] = b;
            m_cnt++;
            if (m_cnt == W) begin
                for (int i = 0; i < W; i++) begin
                    m_lsb[i] = m_bits[i];
                    m_msb[W-1-i] = m_bits[i];
                end
                m_cnt = 0;
                m_valid = 1'b1;
                done = 1'b1;
                m_words++;
            end
        end
        if (!done && xfer) m_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [W-1:0] wv;
        logic rdy;
        int cyc;

        #12;
        chk("reset_valid", 32'(out_valid1), 32'd0);
        chk("reset_data", 32'(out_data1), 32'd0);
        chk("reset_index", 32'(bit_index1), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // 1/2: bits 1,0,1,1,0,0,1,0 back-to-back
        wv = 8'h4D;
        for (int i = 0; i < W; i++) begin
            step(1'b1, wv[i], 1'b1, 1'b0, rdy);
            if (i == W-2) chk("t1_valid_before", 32'(out_valid1), 32'd0);
        end
        chk("t1_valid", 32'(out_valid1), 32'd1);
        chk("t1_data_lsb", 32'(out_data1), 32'h4D);
        chk("t2_data_msb", 32'(out_data0), 32'hB2);

        // 3: output stalls while the next word arrives
        wv = 8'h3C;
        for (int i = 0; i < W-1; i++) step(1'b1, wv[i], 1'b0, 1'b0, rdy);
        chk("t3_hold", 32'(out_data1), 32'h4D);
        chk("t3_index7", 32'(bit_index1), 32'd7);
        step(1'b1, wv[W-1], 1'b0, 1'b0, rdy);
        chk("t3_blocked", 32'(rdy), 32'd0);
        chk("t3_still7", 32'(bit_index1), 32'd7);
        step(1'b1, wv[W-1], 1'b1, 1'b0, rdy);
        chk("t3_ready", 32'(rdy), 32'd1);
        chk("t3_valid", 32'(out_valid1), 32'd1);
        chk("t3_word2", 32'(out_data1), 32'h3C);

        // 4: clear drops the partial word
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 1'b0, rdy);
        step(1'b1, 1'b1, 1'b1, 1'b1, rdy);
        chk("t4_clear_idx", 32'(bit_index1), 32'd0);
        wv = 8'hA5;
        for (int i = 0; i < W; i++) step(1'b1, wv[i], 1'b1, 1'b0, rdy);
        chk("t4_data_lsb", 32'(out_data1), 32'hA5);
        chk("t4_data_msb", 32'(out_data0), 32'hA5);

        // 5: async reset mid-word during an output stall
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 1'b0, rdy);
        chk("t5_idx5", 32'(bit_index1), 32'd5);
        chk("t5_stall", 32'(out_valid1), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("t5_rst_valid", 32'(out_valid1), 32'd0);
        chk("t5_rst_data", 32'(out_data1), 32'd0);
        chk("t5_rst_idx", 32'(bit_index1), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0; clear = 1'b0;

        // 6: 256 random words with bubbles and rare clears
        m_words = 0;
        cyc = 0;
        while (m_words < 256 && cyc < 20000) begin
            step(($urandom_range(0, 3) != 0), 1'($urandom), ($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 99) == 0), rdy);
            cyc++;
        end
        chk("t6_words_done", 32'(m_words >= 256), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
